// File: rtl/rv32imf_idx_scoreboard_if.sv
// -----------------------------------------------------------------------------
// rv32imf_idx_scoreboard_if
// Groups the set/clear/flush/query request side and the pending-state outputs
// of the index scoreboard.
//   slave  : the scoreboard itself (consumes requests, drives state outputs)
//   master : the requester (issue/writeback/flush logic or a testbench)
// Signals:
//   set_valid_i/set_idx_i/set_ready_o : set handshake (valid/ready)
//   clr_valid_i/clr_idx_i             : clear request, always accepted
//   flush_i                           : clear all state on the next edge
//   query_idx_i/query_busy_o          : single-bit lookup of pending state
//   pending_o/count_o/empty_o/full_o  : registered pending vector and summary
//   err_o                             : sticky protocol-error flag
// -----------------------------------------------------------------------------
interface rv32imf_idx_scoreboard_if #(
    parameter int LEN = 32
);
    localparam int IW = $clog2(LEN);

    logic          set_valid_i;
    logic [IW-1:0] set_idx_i;
    logic          set_ready_o;
    logic          clr_valid_i;
    logic [IW-1:0] clr_idx_i;
    logic          flush_i;
    logic [IW-1:0] query_idx_i;
    logic          query_busy_o;
    logic [LEN-1:0] pending_o;
    logic [IW:0]   count_o;
    logic          empty_o;
    logic          full_o;
    logic          err_o;

    modport slave (
        input  set_valid_i, set_idx_i, clr_valid_i, clr_idx_i, flush_i, query_idx_i,
        output set_ready_o, query_busy_o, pending_o, count_o, empty_o, full_o, err_o
    );

    modport master (
        output set_valid_i, set_idx_i, clr_valid_i, clr_idx_i, flush_i, query_idx_i,
        input  set_ready_o, query_busy_o, pending_o, count_o, empty_o, full_o, err_o
    );
endinterface

// File: rtl/rv32imf_idx_scoreboard.sv
// -----------------------------------------------------------------------------
// rv32imf_idx_scoreboard
// Index-driven pending-bit scoreboard. Issue sets a bit, writeback clears it,
// flush wipes everything. Pending vector, population count, empty/full and a
// sticky error flag are all registered; set_ready_o and query_busy_o are
// combinational from the registers only.
// Ports:
//   clk_i  : clock, rising edge
//   rst_ni : asynchronous active-low reset
//   sb     : rv32imf_idx_scoreboard_if.slave (requests in, state out)
// -----------------------------------------------------------------------------
module rv32imf_idx_scoreboard #(
    parameter int LEN = 32
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    rv32imf_idx_scoreboard_if.slave  sb
);
    localparam int          IW    = $clog2(LEN);
    localparam int          PW    = 1 << IW;   // every encodable index
    localparam int          CW    = IW + 1;
    localparam logic [31:0] LEN_U = LEN;

    logic [LEN-1:0] pending_q, pending_d;
    logic [CW-1:0]  count_q, count_d;
    logic           empty_q, full_q, err_q, err_d;

    // Pending vector zero-extended to every encodable index, so out-of-range
    // indices read as "not pending" without any out-of-bounds select.
    logic [PW-1:0]  pend_ext;
    logic [PW-1:0]  pend_nx;
    assign pend_ext = PW'(pending_q);

    logic set_ok, clr_ok, set_ready, set_fire, clr_eff, err_hit;

    assign set_ok    = (32'(sb.set_idx_i) < LEN_U);
    assign clr_ok    = (32'(sb.clr_idx_i) < LEN_U);

    // No bypass: readiness looks at the registered bit only, so a clear in
    // this cycle frees the index for a set only from the next cycle.
    assign set_ready = set_ok & ~pend_ext[sb.set_idx_i] & ~sb.flush_i;
    assign set_fire  = sb.set_valid_i & set_ready;
    assign clr_eff   = sb.clr_valid_i & clr_ok & pend_ext[sb.clr_idx_i];

    // Clear of an empty or out-of-range slot, or set of an out-of-range slot.
    // A set against a busy bit is a stall, not an error.
    assign err_hit   = (sb.clr_valid_i & ~clr_eff) | (sb.set_valid_i & ~set_ok);

    always_comb begin
        pend_nx   = pend_ext;
        pending_d = pending_q;
        count_d   = count_q;
        err_d     = err_q;
        if (sb.flush_i) begin
            pending_d = '0;
            count_d   = '0;
            err_d     = 1'b0;
        end else begin
            // Both sides evaluated against pending_q, then applied together.
            if (clr_eff)  pend_nx[sb.clr_idx_i] = 1'b0;
            if (set_fire) pend_nx[sb.set_idx_i] = 1'b1;
            pending_d = LEN'(pend_nx);
            // Gating on ready/clr_eff keeps this inside 0..LEN.
            count_d   = count_q + CW'(set_fire) - CW'(clr_eff);
            err_d     = err_q | err_hit;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            pending_q <= '0;
            count_q   <= '0;
            empty_q   <= 1'b1;
            full_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            pending_q <= pending_d;
            count_q   <= count_d;
            empty_q   <= (count_d == '0);
            full_q    <= (count_d == CW'(LEN));
            err_q     <= err_d;
        end
    end

    assign sb.set_ready_o  = set_ready;
    assign sb.query_busy_o = pend_ext[sb.query_idx_i];
    assign sb.pending_o    = pending_q;
    assign sb.count_o      = count_q;
    assign sb.empty_o      = empty_q;
    assign sb.full_o       = full_q;
    assign sb.err_o        = err_q;

endmodule
